// File: rtl/mem_stage.sv
// RV32I memory-access stage: ALU passthrough, req/ack data-memory access, load formatting, stall control.
// Optional MEM_MISALIGN_TRAP_EN: traps misaligned half/word accesses instead of issuing them.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_memop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_mem_sdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        stall_req,
    output logic        mem_bus_err
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        mem_excp_misalign
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        load_q, load_d;
    logic [2:0]  fn3_q, fn3_d;
    logic [1:0]  alo_q, alo_d;

    logic        is_mem, is_store;
    logic [2:0]  fn3;
    logic [1:0]  alo;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;
    logic        misalign;

    logic [4:0]  mem_wd_c;
    logic        mem_wreg_c;
    logic [31:0] mem_wdata_c;
    logic        stall_c;
    logic        bus_err_c;
    logic        misalign_c;

    assign is_mem   = ex_valid & ex_memop[4];
    assign is_store = ex_memop[3];
    assign fn3      = ex_memop[2:0];
    assign alo      = ex_mem_addr[1:0];

    // Store lane steering; unused funct3 encodings behave as word accesses.
    always_comb begin
        st_be    = 4'hF;
        st_wdata = ex_mem_sdata;
        case (fn3)
            3'd0: begin
                st_be    = 4'b0001 << alo;
                st_wdata = {4{ex_mem_sdata[7:0]}};
            end
            3'd1: begin
                st_be    = alo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex_mem_sdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = rdata_q[7:0];
        case (alo_q)
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            2'd3:    ld_byte = rdata_q[31:24];
            default: ;
        endcase
        ld_half = alo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (fn3_q)
            3'd0:    ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_fmt = {24'h0, ld_byte};
            3'd1:    ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'd5:    ld_fmt = {16'h0, ld_half};
            default: ld_fmt = rdata_q;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        if (is_store) begin
            if (fn3 == 3'd1)      misalign = alo[0];
            else if (fn3 != 3'd0) misalign = (alo != 2'd0);
        end else begin
            if (fn3 == 3'd1 || fn3 == 3'd5)      misalign = alo[0];
            else if (fn3 != 3'd0 && fn3 != 3'd4) misalign = (alo != 2'd0);
        end
    end
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        load_d      = load_q;
        fn3_d       = fn3_q;
        alo_d       = alo_q;
        mem_wd_c    = ex_wd;
        mem_wreg_c  = 1'b0;
        mem_wdata_c = ex_wdata;
        stall_c     = 1'b0;
        bus_err_c   = 1'b0;
        misalign_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!is_mem) begin
                    mem_wreg_c = ex_wreg & ex_valid;
                end else if (misalign) begin
                    misalign_c = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {ex_mem_addr[31:2], 2'b00};
                    be_d    = is_store ? st_be : 4'hF;
                    wdata_d = is_store ? st_wdata : 32'h0;
                    cnt_d   = 32'h0;
                    load_d  = ~is_store;
                    fn3_d   = fn3;
                    alo_d   = alo;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (dmem_ack) begin
                    rdata_d = dmem_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    // Abort on the last allowed BUSY cycle; a zero limit waits forever.
                    if (TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_CYCLES - 1) begin
                        req_d   = 1'b0;
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                mem_wreg_c  = ex_wreg;
                mem_wdata_c = load_q ? ld_fmt : ex_wdata;
                bus_err_c   = err_q;
                err_d       = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 32'h0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            fn3_q   <= 3'h0;
            alo_q   <= 2'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            load_q  <= load_d;
            fn3_q   <= fn3_d;
            alo_q   <= alo_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

    // Pipeline-facing outputs are combinational, so they are gated while reset is held.
    assign mem_wd      = rst ? mem_wd_c : 5'h0;
    assign mem_wreg    = rst & mem_wreg_c;
    assign mem_wdata   = rst ? mem_wdata_c : 32'h0;
    assign stall_req   = rst & stall_c;
    assign mem_bus_err = rst & bus_err_c;
`ifdef MEM_MISALIGN_TRAP_EN
    assign mem_excp_misalign = rst & misalign_c;
`endif

endmodule
